// File: rtl/serdes_tx_pkg.sv
// Shared types and helpers for the transmit FFE serializer.
// Also holds the PRBS7 constants used when TX_PRBS_EN is defined.
package serdes_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // PRBS7, x^7 + x^6 + 1: feedback from the two oldest stages.
    localparam logic [6:0] PRBS7_SEED  = 7'h7F;
    localparam int         PRBS7_TAP_A = 6;
    localparam int         PRBS7_TAP_B = 5;

    function automatic int ffe_sat(
        input logic signed [1:0] s,
        input logic signed [1:0] p,
        input int                main_tap,
        input int                post_tap,
        input int                out_w
    );
        int raw;
        int lim;
        raw = int'(s) * main_tap - int'(p) * post_tap;
        lim = (1 << (out_w - 1)) - 1;
        if (raw > lim) begin
            return lim;
        end
        if (raw < -lim) begin
            return -lim;
        end
        return raw;
    endfunction

endpackage

// File: rtl/tx_ffe_tap.sv
// Two-tap de-emphasis: current symbol times main cursor minus previous symbol times post cursor.
// The result is saturated symmetrically, so the most negative code is never produced.
module tx_ffe_tap
    import serdes_tx_pkg::*;
#(
    parameter int OUT_W    = 8,
    parameter int MAIN_TAP = 96,
    parameter int POST_TAP = 32
) (
    input  logic signed [1:0]       sym_i,
    input  logic signed [1:0]       prev_i,
    output logic signed [OUT_W-1:0] level_o
);

    // Tap magnitudes stay below 2^(OUT_W-1), so the sum fits OUT_W+2 bits before clamping.
    assign level_o = OUT_W'(ffe_sat(sym_i, prev_i, MAIN_TAP, POST_TAP, OUT_W));

endmodule

// File: rtl/tx_ffe_serializer.sv
// Word-to-bit serializer (LSB first) with registered 2-tap FFE line level.
// Define TX_PRBS_EN to add the Prbs_mode input and a PRBS7 pattern source.
module tx_ffe_serializer
    import serdes_tx_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int OUT_W    = 8,
    parameter int MAIN_TAP = 96,
    parameter int POST_TAP = 32
) (
    input  logic                    CLK,
    input  logic                    Rst,
    input  logic [WIDTH-1:0]        Data_in,
    input  logic                    Data_valid,
`ifdef TX_PRBS_EN
    input  logic                    Prbs_mode,
`endif
    output logic                    Data_ready,
    output logic signed [OUT_W-1:0] Data_out,
    output logic                    Tx_idle
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    tx_state_t               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH-2:0]        shift_q, shift_d;
    logic signed [1:0]       prev_q, prev_d;
    logic signed [1:0]       sym;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic signed [OUT_W-1:0] level;
    logic                    word_ready;
    logic                    accept;
    logic                    drive;
    logic                    tx_bit;

    // cnt_q holds the index of the bit currently on Data_out; ready opens while the last bit shows.
    assign word_ready = (state_q == IDLE) || ((state_q == SEND) && (cnt_q == LAST_IDX));
    assign accept     = Data_valid && Data_ready;

`ifdef TX_PRBS_EN
    logic [6:0] lfsr_q, lfsr_d, lfsr_cur;
    logic       mode_q;
    logic       prbs_bit;

    assign lfsr_cur   = (Prbs_mode && !mode_q) ? PRBS7_SEED : lfsr_q;
    assign prbs_bit   = lfsr_cur[PRBS7_TAP_A] ^ lfsr_cur[PRBS7_TAP_B];
    assign lfsr_d     = Prbs_mode ? {lfsr_cur[5:0], prbs_bit} : lfsr_q;
    assign Data_ready = word_ready && !Prbs_mode;
    assign Tx_idle    = (state_q == IDLE) && !mode_q;
`else
    assign Data_ready = word_ready;
    assign Tx_idle    = (state_q == IDLE);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        drive   = 1'b0;
        tx_bit  = 1'b0;
        if (accept) begin
            drive   = 1'b1;
            tx_bit  = Data_in[0];
            state_d = SEND;
            cnt_d   = '0;
            shift_d = Data_in[WIDTH-1:1];
        end else if (state_q == SEND) begin
            if (cnt_q == LAST_IDX) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                drive   = 1'b1;
                tx_bit  = shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
`ifdef TX_PRBS_EN
        // Pattern mode abandons any word in flight and parks the word path in IDLE.
        if (Prbs_mode) begin
            drive   = 1'b1;
            tx_bit  = prbs_bit;
            state_d = IDLE;
            cnt_d   = '0;
        end
`endif
    end

    assign sym    = tx_bit ? 2'sb01 : 2'sb11;
    assign out_d  = drive ? level : '0;
    assign prev_d = drive ? sym : 2'sb00;

    tx_ffe_tap #(
        .OUT_W   (OUT_W),
        .MAIN_TAP(MAIN_TAP),
        .POST_TAP(POST_TAP)
    ) u_tap (
        .sym_i  (sym),
        .prev_i (prev_q),
        .level_o(level)
    );

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            prev_q  <= 2'sb00;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            prev_q  <= prev_d;
            out_q   <= out_d;
        end
    end

`ifdef TX_PRBS_EN
    always_ff @(posedge CLK) begin
        if (Rst) begin
            lfsr_q <= PRBS7_SEED;
            mode_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            mode_q <= Prbs_mode;
        end
    end
`endif

    assign Data_out = out_q;

endmodule

// File: tb/tb_tx_ffe_serializer.sv
// Bench for tx_ffe_serializer: directed vector table, mid-word reset sequence, random traffic vs model.
// The PRBS7 check is compiled only when TX_PRBS_EN is defined.
module tb_tx_ffe_serializer;

    localparam int WIDTH = 10;
    localparam int OUT_W = 8;
    localparam int MAIN  = 96;
    localparam int POST  = 32;
    localparam int LIM   = 127;

    logic                    CLK = 1'b0;
    logic                    Rst;
    logic [WIDTH-1:0]        Data_in;
    logic                    Data_valid;
    logic                    Data_ready;
    logic signed [OUT_W-1:0] Data_out;
    logic                    Tx_idle;
`ifdef TX_PRBS_EN
    logic                    Prbs_mode;
`endif

    always #5 CLK = ~CLK;

    tx_ffe_serializer #(
        .WIDTH   (WIDTH),
        .OUT_W   (OUT_W),
        .MAIN_TAP(MAIN),
        .POST_TAP(POST)
    ) dut (
        .CLK       (CLK),
        .Rst       (Rst),
        .Data_in   (Data_in),
        .Data_valid(Data_valid),
`ifdef TX_PRBS_EN
        .Prbs_mode (Prbs_mode),
`endif
        .Data_ready(Data_ready),
        .Data_out  (Data_out),
        .Tx_idle   (Tx_idle)
    );

    typedef struct {
        logic             rst;
        logic             valid;
        logic [WIDTH-1:0] data;
        int               exp_out;
        logic             exp_idle;
        logic             exp_rdy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Random-traffic model: pending bits of the word on the line, previous symbol, expected level.
    bit   m_busy;
    bit   m_pend[$];
    int   m_prev;
    int   m_out;

    task automatic add(input logic r, input logic v, input logic [WIDTH-1:0] d,
                       input int o, input logic idl, input logic rdy);
        vec_t t;
        t.rst      = r;
        t.valid    = v;
        t.data     = d;
        t.exp_out  = o;
        t.exp_idle = idl;
        t.exp_rdy  = rdy;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lvl(input int s, input int p);
        int v;
        v = s * MAIN - p * POST;
        if (v > LIM) v = LIM;
        if (v < -LIM) v = -LIM;
        return v;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [WIDTH-1:0] d);
        int s;
        if (r) begin
            m_busy = 0;
            m_pend.delete();
            m_prev = 0;
            m_out  = 0;
        end else if (v && (!m_busy || m_pend.size() == 0)) begin
            m_busy = 1;
            m_pend.delete();
            for (int i = 1; i < WIDTH; i++) m_pend.push_back(d[i]);
            s      = d[0] ? 1 : -1;
            m_out  = lvl(s, m_prev);
            m_prev = s;
        end else if (m_busy && m_pend.size() > 0) begin
            s      = m_pend.pop_front() ? 1 : -1;
            m_out  = lvl(s, m_prev);
            m_prev = s;
        end else begin
            m_busy = 0;
            m_out  = 0;
            m_prev = 0;
        end
    endtask

    initial begin
        Rst        = 1'b1;
        Data_valid = 1'b0;
        Data_in    = '0;
`ifdef TX_PRBS_EN
        Prbs_mode  = 1'b0;
`endif

        // reset held three cycles
        for (int i = 0; i < 3; i++) add(1, 0, 10'h000, 0, 1, 1);
        // all-ones word, then valid dropped
        add(0, 1, 10'h3FF, 96, 0, 0);
        for (int i = 1; i < 9; i++) add(0, 0, 10'h000, 64, 0, 0);
        add(0, 0, 10'h000, 64, 0, 1);
        add(0, 0, 10'h000, 0, 1, 1);
        // alternating word saturates both ways
        add(0, 1, 10'h155, 96, 0, 0);
        for (int k = 1; k < 9; k++) add(0, 0, 10'h000, (k % 2 == 1) ? -127 : 127, 0, 0);
        add(0, 0, 10'h000, -127, 0, 1);
        add(0, 0, 10'h000, 0, 1, 1);
        // back-to-back words with valid held; Data_in changes while not ready
        add(0, 1, 10'h000, -96, 0, 0);
        for (int k = 1; k < 9; k++) add(0, 1, 10'h3FF, -64, 0, 0);
        add(0, 1, 10'h3FF, -64, 0, 1);
        add(0, 1, 10'h3FF, 127, 0, 0);
        for (int k = 1; k < 9; k++) add(0, 0, 10'h000, 64, 0, 0);
        add(0, 0, 10'h000, 64, 0, 1);
        add(0, 0, 10'h000, 0, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            Rst        = vecs[i].rst;
            Data_valid = vecs[i].valid;
            Data_in    = vecs[i].data;
            @(negedge CLK);
            check($sformatf("vec%0d_out", i), int'(Data_out), vecs[i].exp_out);
            check($sformatf("vec%0d_idle", i), int'(Tx_idle), int'(vecs[i].exp_idle));
            check($sformatf("vec%0d_ready", i), int'(Data_ready), int'(vecs[i].exp_rdy));
        end

        // reset while bit 4 is on the line
        Rst = 1'b0; Data_valid = 1'b1; Data_in = 10'h3FF;
        @(negedge CLK);
        check("midrst_bit0", int'(Data_out), 96);
        Data_valid = 1'b0;
        repeat (4) @(negedge CLK);
        check("midrst_bit4", int'(Data_out), 64);
        Rst = 1'b1;
        @(negedge CLK);
        check("midrst_out", int'(Data_out), 0);
        check("midrst_idle", int'(Tx_idle), 1);
        check("midrst_ready", int'(Data_ready), 1);
        Rst = 1'b0;
        @(negedge CLK);
        check("postrst_out", int'(Data_out), 0);
        check("postrst_idle", int'(Tx_idle), 1);
        Data_valid = 1'b1; Data_in = 10'h002;
        @(negedge CLK);
        check("restart_bit0", int'(Data_out), -96);
        Data_valid = 1'b0;
        @(negedge CLK);
        check("restart_bit1", int'(Data_out), 127);
        repeat (9) @(negedge CLK);
        check("restart_end_out", int'(Data_out), 0);
        check("restart_end_idle", int'(Tx_idle), 1);

        // random traffic against the model
        Rst = 1'b1; Data_valid = 1'b0;
        model_step(1, 0, '0);
        for (int c = 0; c < 800; c++) begin
            bit               r;
            bit               v;
            logic [WIDTH-1:0] d;
            @(negedge CLK);
            check("rand_out", int'(Data_out), m_out);
            check("rand_idle", int'(Tx_idle), int'(!m_busy));
            check("rand_ready", int'(Data_ready), int'(!m_busy || m_pend.size() == 0));
            r = ($urandom_range(0, 59) == 0);
            v = 1'($urandom_range(0, 1));
            d = WIDTH'($urandom);
            Rst        = r;
            Data_valid = v;
            Data_in    = d;
            model_step(r, v, d);
        end

`ifdef TX_PRBS_EN
        begin
            int seq[0:270];
            Rst = 1'b0; Data_valid = 1'b1; Prbs_mode = 1'b1;
            for (int i = 0; i < 7; i++) seq[i] = 1;
            for (int n = 0; n + 7 <= 270; n++) seq[n + 7] = seq[n + 1] ^ seq[n];
            for (int k = 0; k < 254; k++) begin
                @(negedge CLK);
                check($sformatf("prbs_bit%0d", k), int'(Data_out > 0), seq[k + 7]);
                check("prbs_ready", int'(Data_ready), 0);
                check("prbs_idle", int'(Tx_idle), 0);
            end
            Prbs_mode = 1'b0; Data_valid = 1'b0;
            @(negedge CLK);
            check("prbs_exit_out", int'(Data_out), 0);
            check("prbs_exit_idle", int'(Tx_idle), 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
